// File: rtl/io_bus_ctrl_if.sv
// CPU, RAM and UART signals around io_bus_ctrl, grouped into one bus.
// slave is the controller's view; master is the view of the cpu/ram/uart side.
interface io_bus_ctrl_if;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [16:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        halted;

  modport slave (
    input  cpu_a, cpu_wr, cpu_dout, ram_din, tx_ready, rx_data, rx_valid,
    output cpu_din, cpu_rdy, ram_a, ram_wr, ram_dout, tx_data, tx_valid, rx_pop, halted
  );

  modport master (
    output cpu_a, cpu_wr, cpu_dout, ram_din, tx_ready, rx_data, rx_valid,
    input  cpu_din, cpu_rdy, ram_a, ram_wr, ram_dout, tx_data, tx_valid, rx_pop, halted
  );
endinterface

// File: rtl/io_bus_ctrl.sv
// CPU bus splitter: 128KB RAM pass-through plus an I/O window holding the UART TX FIFO,
// the RX pop path, a free-running cycle counter with byte snapshot, and a sticky halt flag.
module io_bus_ctrl #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int CNT_W         = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  io_bus_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RX_WAIT = 2'd1,
    TX_FULL = 2'd2
  } state_t;

  localparam int                     DEPTH    = 1 << TX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] PTR_ONE  = 1;
  localparam logic [CNT_W-1:0]       CNT_ONE  = 1;
  localparam logic [2:0]             REG_DATA = 3'd0;
  localparam logic [2:0]             REG_CNT0 = 3'd4;
  localparam logic [2:0]             REG_CNT1 = 3'd5;
  localparam logic [2:0]             REG_CNT2 = 3'd6;
  localparam logic [2:0]             REG_CNT3 = 3'd7;

  state_t                 state;
  logic [7:0]             fifo_mem [DEPTH];
  logic [TX_DEPTH_LOG2:0] wr_ptr;
  logic [TX_DEPTH_LOG2:0] rd_ptr;
  logic [CNT_W-1:0]       cycle_cnt;
  logic [CNT_W-1:0]       snap;
  logic                   sel_q;
  logic [7:0]             io_q;
  logic                   halted_q;

  logic       io_sel;
  logic       io_rd;
  logic       io_wr;
  logic [2:0] reg_a;
  logic       fifo_empty;
  logic       fifo_full;
  logic       tx_pop;
  logic       push_req;
  logic       push_ok;
  logic [7:0] push_data;
  logic       rx_req;
  logic       rx_take;
  logic       cpu_rdy;
  logic       unused_addr;

  assign io_sel      = (bus.cpu_a[17:16] == 2'b11);
  assign reg_a       = bus.cpu_a[2:0];
  assign io_rd       = io_sel & ~bus.cpu_wr;
  assign io_wr       = io_sel & bus.cpu_wr;
  assign unused_addr = ^bus.cpu_a[31:18];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr == {~rd_ptr[TX_DEPTH_LOG2], rd_ptr[TX_DEPTH_LOG2-1:0]});
  assign tx_pop     = ~fifo_empty & bus.tx_ready;

  // A zero byte to the data register is a no-op; the halt register always pushes 0x00.
  assign push_req  = rst_in & io_wr &
                     (((reg_a == REG_DATA) && (bus.cpu_dout != 8'h00)) || (reg_a == REG_CNT0));
  assign push_ok   = push_req & (~fifo_full | tx_pop);
  assign push_data = (reg_a == REG_CNT0) ? 8'h00 : bus.cpu_dout;

  assign rx_req  = rst_in & io_rd & (reg_a == REG_DATA);
  assign rx_take = rx_req & bus.rx_valid;

  always_comb begin
    // NOTE: default assigned first so every path drives cpu_rdy and no latch is inferred.
    cpu_rdy = 1'b1;
    if (rst_in) begin
      case (state)
        RUN:     cpu_rdy = ~(rx_req & ~bus.rx_valid) & ~(push_req & ~push_ok);
        RX_WAIT: cpu_rdy = rx_take;
        TX_FULL: cpu_rdy = push_ok;
        default: cpu_rdy = 1'b1;
      endcase
    end
  end

  assign bus.cpu_rdy  = cpu_rdy;
  assign bus.cpu_din  = sel_q ? io_q : bus.ram_din;
  assign bus.ram_a    = bus.cpu_a[16:0];
  assign bus.ram_dout = bus.cpu_dout;
  assign bus.ram_wr   = bus.cpu_wr & ~io_sel & cpu_rdy;
  assign bus.tx_data  = fifo_mem[rd_ptr[TX_DEPTH_LOG2-1:0]];
  assign bus.tx_valid = ~fifo_empty;
  assign bus.rx_pop   = rx_take;
  assign bus.halted   = halted_q;

  // NOTE: FIFO storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      fifo_mem[wr_ptr[TX_DEPTH_LOG2-1:0]] <= push_data;
    end
  end

  // NOTE: all state here updates with <= so every register sees pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cycle_cnt <= '0;
      snap      <= '0;
      sel_q     <= 1'b1;   // with io_q = 0 this presents cpu_din = 0 out of reset
      io_q      <= 8'h00;
      halted_q  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      sel_q     <= io_sel;

      if (tx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;

      if (push_ok && (reg_a == REG_CNT0)) halted_q <= 1'b1;

      if (io_rd && cpu_rdy) begin
        case (reg_a)
          REG_DATA: io_q <= bus.rx_data;
          REG_CNT0: begin
            io_q <= cycle_cnt[7:0];
            snap <= cycle_cnt;
          end
          REG_CNT1: io_q <= snap[15:8];
          REG_CNT2: io_q <= snap[23:16];
          REG_CNT3: io_q <= snap[31:24];
          default:  io_q <= 8'h00;
        endcase
      end

      case (state)
        RUN: begin
          if (rx_req && !bus.rx_valid)  state <= RX_WAIT;
          else if (push_req && !push_ok) state <= TX_FULL;
        end
        RX_WAIT: if (rx_take || !rx_req)   state <= RUN;
        TX_FULL: if (push_ok || !push_req) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed and randomized checks of io_bus_ctrl against a queue/array reference of the
// RAM contents, TX byte stream and cycle counter.
module tb_io_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  io_bus_ctrl_if bus();

  io_bus_ctrl #(.TX_DEPTH_LOG2(4), .CNT_W(32)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram_mem [0:131071];
  logic [7:0]  shadow [logic [16:0]];
  logic [16:0] ram_keys [$];
  logic [7:0]  tx_seen [$];
  logic [7:0]  tx_exp  [$];
  int unsigned cyc = 0;
  bit          rand_ready = 1'b0;

  // TX byte monitor: every handshake the UART side sees
  always @(posedge clk) begin
    if (rst_n && bus.tx_valid && bus.tx_ready) tx_seen.push_back(bus.tx_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: external RAM answers one cycle late, counter model advances.
  task automatic tick();
    logic        w;
    logic [16:0] a;
    logic [7:0]  d;
    @(negedge clk);
    w = bus.ram_wr;
    a = bus.ram_a;
    d = bus.ram_dout;
    @(posedge clk);
    #1;
    cyc = rst_n ? cyc + 1 : 0;
    bus.ram_din = ram_mem[a];
    if (w) ram_mem[a] = d;
    if (rand_ready) bus.tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic bus_idle();
    bus.cpu_a    = 32'h0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_dout = 8'h00;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d,
                           input int max_wait, output int stalls);
    bus.cpu_a    = a;
    bus.cpu_wr   = 1'b1;
    bus.cpu_dout = d;
    stalls       = 0;
    #1;
    while (!bus.cpu_rdy && stalls < max_wait) begin
      tick();
      #1;
      stalls++;
    end
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, input int max_wait,
                          output logic [7:0] d, output int stalls);
    bus.cpu_a  = a;
    bus.cpu_wr = 1'b0;
    stalls     = 0;
    #1;
    while (!bus.cpu_rdy && stalls < max_wait) begin
      tick();
      #1;
      stalls++;
    end
    tick();
    bus_idle();
    #1;
    d = bus.cpu_din;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rand_ready   = 1'b0;
    bus.tx_ready = 1'b1;
    while (bus.tx_valid && n < 100) begin
      tick();
      n++;
    end
    bus.tx_ready = 1'b0;
    check({tag, "_empty"}, bus.tx_valid, 1'b0);
    check({tag, "_count"}, tx_seen.size(), tx_exp.size());
    for (int i = 0; i < tx_exp.size() && i < tx_seen.size(); i++)
      check({tag, "_byte"}, tx_seen[i], tx_exp[i]);
    tx_seen.delete();
    tx_exp.delete();
  endtask

  initial begin
    int          st;
    logic [7:0]  d;
    int unsigned snap_exp;
    int unsigned snap2_exp;

    bus_idle();
    bus.ram_din  = 8'h00;
    bus.tx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst_n        = 1'b0;

    // ---- reset: outputs idle even with a pending RX read on the bus
    tick();
    bus.cpu_a    = 32'h30000;
    bus.rx_valid = 1'b1;
    tick();
    #1;
    check("rst_cpu_din", bus.cpu_din, 8'h00);
    check("rst_cpu_rdy", bus.cpu_rdy, 1'b1);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_rx_pop", bus.rx_pop, 1'b0);
    check("rst_halted", bus.halted, 1'b0);
    bus.rx_valid = 1'b0;
    bus_idle();
    rst_n = 1'b1;
    tick();

    // ---- RAM write then read back
    bus.cpu_a    = 32'h00123;
    bus.cpu_wr   = 1'b1;
    bus.cpu_dout = 8'hAB;
    #1;
    check("ram_wr_high", bus.ram_wr, 1'b1);
    check("ram_a", bus.ram_a, 17'h00123);
    check("ram_dout", bus.ram_dout, 8'hAB);
    tick();
    bus_idle();
    #1;
    check("ram_wr_one_cycle", bus.ram_wr, 1'b0);
    bus_read(32'h00123, 0, d, st);
    check("ram_read_data", d, 8'hAB);
    shadow[17'h00123] = 8'hAB;
    ram_keys.push_back(17'h00123);

    // ---- TX writes, zero byte dropped, no stall
    bus.tx_ready = 1'b1;
    bus_write(32'h30000, 8'h41, 0, st); check("tx41_nostall", st, 0); tx_exp.push_back(8'h41);
    bus_write(32'h30000, 8'h00, 0, st); check("tx00_nostall", st, 0);
    bus_write(32'h30000, 8'h42, 0, st); check("tx42_nostall", st, 0); tx_exp.push_back(8'h42);
    drain("tx_basic");

    // ---- FIFO full: 16 accepted, 17th stalls until a pop
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus_write(32'h30000, 8'h55, 0, st);
      check("fill_nostall", st, 0);
      tx_exp.push_back(8'h55);
    end
    bus.cpu_a    = 32'h30000;
    bus.cpu_wr   = 1'b1;
    bus.cpu_dout = 8'h55;
    #1;
    check("full_rdy_low", bus.cpu_rdy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("full_rdy_hold", bus.cpu_rdy, 1'b0);
    end
    bus.tx_ready = 1'b1;
    #1;
    check("full_rdy_on_pop", bus.cpu_rdy, 1'b1);
    tick();
    bus.tx_ready = 1'b0;
    bus_idle();
    tx_exp.push_back(8'h55);
    #1;
    check("full_rdy_after", bus.cpu_rdy, 1'b1);
    drain("tx_full");

    // ---- RX read blocks 5 cycles, then pops once
    bus.cpu_a  = 32'h30000;
    bus.cpu_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rx_wait_rdy", bus.cpu_rdy, 1'b0);
      check("rx_wait_pop", bus.rx_pop, 1'b0);
      tick();
    end
    bus.rx_data  = 8'h7E;
    bus.rx_valid = 1'b1;
    #1;
    check("rx_rdy", bus.cpu_rdy, 1'b1);
    check("rx_pop", bus.rx_pop, 1'b1);
    tick();
    bus.rx_valid = 1'b0;
    bus_idle();
    #1;
    check("rx_din", bus.cpu_din, 8'h7E);
    check("rx_pop_pulse", bus.rx_pop, 1'b0);

    // ---- unmapped I/O
    bus_read(32'h30002, 0, d, st);
    check("io_unmapped_rd", d, 8'h00);
    bus_write(32'h30001, 8'h99, 0, st);
    #1;
    check("io_unmapped_wr", bus.tx_valid, 1'b0);

    // ---- halt register, then reset mid-drain
    bus_write(32'h30000, 8'h41, 0, st);
    bus_write(32'h30004, 8'hFF, 0, st);
    check("halt_nostall", st, 0);
    bus_write(32'h30000, 8'h42, 0, st);
    #1;
    check("halted_set", bus.halted, 1'b1);
    bus.tx_ready = 1'b1;
    tick();
    tick();
    bus.tx_ready = 1'b0;
    #1;
    check("halt_seen_count", tx_seen.size(), 2);
    if (tx_seen.size() >= 2) begin
      check("halt_seen0", tx_seen[0], 8'h41);
      check("halt_seen1_zero", tx_seen[1], 8'h00);
    end
    check("halt_mid_valid", bus.tx_valid, 1'b1);
    check("halt_mid_data", bus.tx_data, 8'h42);
    check("halted_sticky", bus.halted, 1'b1);
    rst_n = 1'b0;
    tick();
    #1;
    check("halt_rst_halted", bus.halted, 1'b0);
    check("halt_rst_tx_valid", bus.tx_valid, 1'b0);
    check("halt_rst_din", bus.cpu_din, 8'h00);
    tx_seen.delete();
    tx_exp.delete();
    rst_n = 1'b1;

    // ---- cycle counter snapshot
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) tick();
    check("cnt_model_1000", cyc, 1000);
    snap_exp = cyc;
    bus_read(32'h30004, 0, d, st);
    check("cnt_b0", d, snap_exp & 32'hFF);
    for (int i = 0; i < 30; i++) tick();
    bus_read(32'h30005, 0, d, st);
    check("cnt_b1_snapshot", d, (snap_exp >> 8) & 32'hFF);
    bus_read(32'h30006, 0, d, st);
    check("cnt_b2", d, (snap_exp >> 16) & 32'hFF);
    bus_read(32'h30007, 0, d, st);
    check("cnt_b3", d, (snap_exp >> 24) & 32'hFF);
    snap2_exp = cyc;
    bus_read(32'h30004, 0, d, st);
    check("cnt_reload_b0", d, snap2_exp & 32'hFF);
    bus_read(32'h30005, 0, d, st);
    check("cnt_reload_b1", d, (snap2_exp >> 8) & 32'hFF);

    // ---- randomized mix against the reference queue and RAM shadow
    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      int unsigned op;
      logic [16:0] a;
      logic [7:0]  v;
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          a = 17'($urandom_range(0, 17'h1FFFF));
          v = 8'($urandom);
          bus_write({15'h0, a}, v, 0, st);
          check("rnd_ram_wr_nostall", st, 0);
          if (!shadow.exists(a)) ram_keys.push_back(a);
          shadow[a] = v;
        end
        1: begin
          a = ram_keys[$urandom_range(0, ram_keys.size() - 1)];
          bus_read({15'h0, a}, 0, d, st);
          check("rnd_ram_rd", d, shadow[a]);
        end
        2: begin
          v = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
          bus_write(32'h30000, v, 500, st);
          check("rnd_tx_bound", st < 500, 1'b1);
          if (v != 8'h00) tx_exp.push_back(v);
        end
        default: begin
          bus_read(32'h30000 | 32'($urandom_range(1, 3)), 0, d, st);
          check("rnd_io_zero", d, 8'h00);
        end
      endcase
    end
    drain("rnd_tx");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
